// File: rtl/level_pkg.sv
// rtl/level_pkg.sv - shared state encoding, channel count and default thresholds for the level scanner
package level_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_CH = 4;

  localparam logic [23:0] LEVEL0_DEF      = 24'h0C_CC_CD;
  localparam logic [23:0] LEVEL1_DEF      = 24'h16_C3_11;
  localparam logic [23:0] LEVEL2_DEF      = 24'h28_7A_26;
  localparam logic [23:0] LEVEL3_DEF      = 24'h47_FA_CC;
  localparam logic [23:0] CLIP_TH_DEF     = 24'h7D_16_1C;
  localparam logic [15:0] HOLD_LENGTH_DEF = 16'd19_531;
  localparam logic [18:0] CLIP_LENGTH_DEF = 19'd390_625;

  // Most negative sample has no positive twin in 24 bits, so it pins to full scale.
  function automatic logic [23:0] sat_abs(input logic [23:0] s);
    if (!s[23])
      return s;
    else if (s == 24'h80_00_00)
      return 24'h7F_FF_FF;
    else
      return -s;
  endfunction

endpackage

// File: rtl/level_compare.sv
// rtl/level_compare.sv - stereo magnitude, four-step thermometer and clip detect for one channel
module level_compare
  import level_pkg::*;
#(
  parameter logic [23:0] Level0 = LEVEL0_DEF,
  parameter logic [23:0] Level1 = LEVEL1_DEF,
  parameter logic [23:0] Level2 = LEVEL2_DEF,
  parameter logic [23:0] Level3 = LEVEL3_DEF,
  parameter logic [23:0] ClipTh = CLIP_TH_DEF
) (
  input  logic [23:0] left_i,
  input  logic [23:0] right_i,
  output logic [3:0]  level_o,
  output logic        clip_hit_o
);

  logic [23:0] mag_l;
  logic [23:0] mag_r;
  logic [23:0] mag;

  always_comb begin
    mag_l      = sat_abs(left_i);
    mag_r      = sat_abs(right_i);
    mag        = (mag_l > mag_r) ? mag_l : mag_r;
    level_o    = {mag > Level3, mag > Level2, mag > Level1, mag > Level0};
    clip_hit_o = (mag >= ClipTh);
  end

endmodule

// File: rtl/level_scan_controller.sv
// rtl/level_scan_controller.sv - 4-channel level meter scanning one channel per cycle; LEVEL_PEAK_HOLD_EN adds peak hold
module level_scan_controller
  import level_pkg::*;
#(
  parameter logic [23:0] Level0     = LEVEL0_DEF,
  parameter logic [23:0] Level1     = LEVEL1_DEF,
  parameter logic [23:0] Level2     = LEVEL2_DEF,
  parameter logic [23:0] Level3     = LEVEL3_DEF,
  parameter logic [23:0] ClipTh     = CLIP_TH_DEF,
  parameter logic [15:0] HoldLength = HOLD_LENGTH_DEF,
  parameter logic [18:0] ClipLength = CLIP_LENGTH_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Valid,
  output logic         Ready,
  input  logic [191:0] Input,
  output logic [15:0]  Level,
  output logic [3:0]   Clip,
  output logic         Update
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [47:0] data_q [NUM_CH];
  logic [3:0]  level_q [NUM_CH];
  logic [18:0] clip_cnt_q [NUM_CH];
  logic [3:0]  clip_q;

  logic [3:0]  inst_lvl;
  logic        clip_hit;
  logic [3:0]  lvl_d;
  logic [18:0] clip_cnt_d;
  logic        clip_bit_d;
  logic        accept;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    Ready   = 1'b0;
    Update  = 1'b0;
    case (state_q)
      IDLE: begin
        Ready = 1'b1;
        if (Valid) begin
          state_d = SCAN;
          idx_d   = 2'd0;
        end
      end
      SCAN: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        Update  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = Valid && Ready;

  level_compare #(
    .Level0 (Level0),
    .Level1 (Level1),
    .Level2 (Level2),
    .Level3 (Level3),
    .ClipTh (ClipTh)
  ) u_compare (
    .left_i     (data_q[idx_q][47:24]),
    .right_i    (data_q[idx_q][23:0]),
    .level_o    (inst_lvl),
    .clip_hit_o (clip_hit)
  );

  always_comb begin
    clip_cnt_d = clip_cnt_q[idx_q];
    clip_bit_d = clip_q[idx_q];
    if (clip_hit) begin
      clip_cnt_d = ClipLength;
      clip_bit_d = 1'b1;
    end else if (clip_cnt_q[idx_q] != 19'd0) begin
      clip_cnt_d = clip_cnt_q[idx_q] - 19'd1;
    end else begin
      clip_bit_d = 1'b0;
    end
  end

`ifdef LEVEL_PEAK_HOLD_EN
  logic [15:0] hold_cnt_q [NUM_CH];
  logic [15:0] hold_cnt_d;

  // Thermometer codes order correctly as plain unsigned values.
  always_comb begin
    lvl_d      = level_q[idx_q];
    hold_cnt_d = hold_cnt_q[idx_q];
    if (inst_lvl > level_q[idx_q]) begin
      lvl_d      = inst_lvl;
      hold_cnt_d = HoldLength;
    end else if (hold_cnt_q[idx_q] != 16'd0) begin
      hold_cnt_d = hold_cnt_q[idx_q] - 16'd1;
    end else begin
      lvl_d      = level_q[idx_q] >> 1;
      hold_cnt_d = HoldLength;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int n = 0; n < NUM_CH; n++) hold_cnt_q[n] <= 16'd0;
    end else if (state_q == SCAN) begin
      hold_cnt_q[idx_q] <= hold_cnt_d;
    end
  end
`else
  logic unused_hold;

  assign unused_hold = ^HoldLength;

  always_comb begin
    lvl_d = inst_lvl;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int n = 0; n < NUM_CH; n++) begin
        data_q[n]     <= 48'd0;
        level_q[n]    <= 4'd0;
        clip_cnt_q[n] <= 19'd0;
      end
      clip_q <= 4'd0;
    end else begin
      if (accept) begin
        for (int n = 0; n < NUM_CH; n++) data_q[n] <= Input[48*n +: 48];
      end
      if (state_q == SCAN) begin
        level_q[idx_q]    <= lvl_d;
        clip_cnt_q[idx_q] <= clip_cnt_d;
        clip_q[idx_q]     <= clip_bit_d;
      end
    end
  end

  always_comb begin
    Level = 16'd0;
    for (int n = 0; n < NUM_CH; n++) Level[4*n +: 4] = level_q[n];
  end

  assign Clip = clip_q;

endmodule

// File: tb/tb_level_scan_controller.sv
// tb/tb_level_scan_controller.sv - directed self-checking bench for level_scan_controller
module tb_level_scan_controller;

  logic         clk;
  logic         rst;
  logic         valid;
  logic         ready;
  logic [191:0] din;
  logic [15:0]  level;
  logic [3:0]   clip;
  logic         update;

  int n_cmp;
  int n_mis;

  level_scan_controller #(
    .HoldLength (16'd2),
    .ClipLength (19'd3)
  ) dut (
    .Clk    (clk),
    .Reset  (rst),
    .Valid  (valid),
    .Ready  (ready),
    .Input  (din),
    .Level  (level),
    .Clip   (clip),
    .Update (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [191:0] frame4(
    input logic [23:0] l0, input logic [23:0] r0,
    input logic [23:0] l1, input logic [23:0] r1,
    input logic [23:0] l2, input logic [23:0] r2,
    input logic [23:0] l3, input logic [23:0] r3);
    return {l3, r3, l2, r2, l1, r1, l0, r0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one frame, scramble Input right after the accept, wait for Update.
  task automatic run_frame(input logic [191:0] d);
    int k;
    int lat;
    k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_accept", {31'd0, ready}, 32'd1);
    valid = 1'b1;
    din   = d;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    din   = ~d;
    lat   = 1;
    while (!update && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("update_latency", lat, 32'd5);
  endtask

  logic [191:0] silent;
  logic [3:0]   exp_clip [4];
  int           ups;
  int           lows;
`ifdef LEVEL_PEAK_HOLD_EN
  logic [3:0]   exp_hold [13];
`endif

  initial begin
    n_cmp  = 0;
    n_mis  = 0;
    rst    = 1'b1;
    valid  = 1'b0;
    din    = '0;
    silent = '0;

    // Reset state
    do_reset();
    check("rst_ready",  {31'd0, ready},  32'd1);
    check("rst_update", {31'd0, update}, 32'd0);
    check("rst_level",  {16'd0, level},  32'd0);
    check("rst_clip",   {28'd0, clip},   32'd0);

    // 0x100000 is about -18 dB: above Level0 only
    run_frame(frame4(24'h100000, 24'h100000, 24'h100000, 24'h100000,
                     24'h100000, 24'h100000, 24'h100000, 24'h100000));
    check("lvl_100000", {16'd0, level}, 32'h1111);
    check("clip_100000", {28'd0, clip}, 32'h0);

    // 0x200000 is about -12 dB: above Level0 and Level1
    do_reset();
    run_frame(frame4(24'h200000, 24'h0, 24'h0, 24'h200000,
                     24'hE00000, 24'h0, 24'h0, 24'hE00000));
    check("lvl_200000", {16'd0, level}, 32'h3333);
    check("clip_200000", {28'd0, clip}, 32'h0);

    // Threshold edges, negative path and clip threshold
    do_reset();
    run_frame(frame4(24'h0CCCCD, 24'hF33333, 24'h0, 24'h0CCCCE,
                     24'h7D161C, 24'h0, 24'h7D161B, 24'h0));
    check("lvl_edges", {16'd0, level}, 32'hFF10);
    check("clip_edges", {28'd0, clip}, 32'h4);

    // Most negative sample clips; clip hold expires on frame ClipLength+1
    do_reset();
    run_frame(frame4(24'h0, 24'h0, 24'h0, 24'h0, 24'h800000, 24'h0, 24'h0, 24'h0));
    check("lvl_neg_fs", {16'd0, level}, 32'h0F00);
    check("clip_neg_fs", {28'd0, clip}, 32'h4);
    exp_clip[0] = 4'h4;
    exp_clip[1] = 4'h4;
    exp_clip[2] = 4'h4;
    exp_clip[3] = 4'h0;
    for (int f = 0; f < 4; f++) begin
      run_frame(silent);
      check($sformatf("clip_decay_%0d", f + 1), {28'd0, clip}, {28'd0, exp_clip[f]});
`ifndef LEVEL_PEAK_HOLD_EN
      check($sformatf("lvl_silent_%0d", f + 1), {16'd0, level}, 32'h0);
`endif
    end

    // Valid held high: accept every 6 cycles
    do_reset();
    valid = 1'b1;
    din   = frame4(24'h300000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("stream_ready_%0d", k), {31'd0, ready}, (k % 6 == 0) ? 32'd1 : 32'd0);
      check($sformatf("stream_update_%0d", k), {31'd0, update}, (k % 6 == 5) ? 32'd1 : 32'd0);
    end
    valid = 1'b0;

    // Reset at SCAN index 2, together with Valid
    do_reset();
    valid = 1'b1;
    din   = frame4(24'h7FFFFF, 24'h0, 24'h7FFFFF, 24'h0, 24'h7FFFFF, 24'h0, 24'h7FFFFF, 24'h0);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_level_partial", {16'd0, level}, 32'h00FF);
    check("mid_clip_partial", {28'd0, clip}, 32'h3);
    rst   = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    check("mid_rst_ready",  {31'd0, ready},  32'd1);
    check("mid_rst_update", {31'd0, update}, 32'd0);
    check("mid_rst_level",  {16'd0, level},  32'd0);
    check("mid_rst_clip",   {28'd0, clip},   32'd0);
    rst   = 1'b0;
    valid = 1'b0;
    ups   = 0;
    lows  = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (update) ups++;
      if (!ready) lows++;
    end
    check("mid_rst_no_update", ups, 32'd0);
    check("mid_rst_no_scan", lows, 32'd0);

`ifdef LEVEL_PEAK_HOLD_EN
    // HoldLength=2: each held value lasts three frames before decaying one step
    exp_hold = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h3, 4'h3, 4'h3, 4'h1, 4'h1, 4'h1, 4'h0};
    do_reset();
    run_frame(frame4(24'h7FFFFF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0));
    check("hold_frame_1", {16'd0, level}, {28'd0, exp_hold[0]});
    for (int f = 1; f < 13; f++) begin
      run_frame(silent);
      check($sformatf("hold_frame_%0d", f + 1), {16'd0, level}, {28'd0, exp_hold[f]});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
